nor_gate_sweep_tester: RTL and testbench
========================================

# nor_gate_sweep_tester

Self-checking stimulus driver and response checker for the lab1 NOR-built logic unit, which has inputs A and B and outputs AND, OR and NOT(A). On `start`, the block applies all four (A,B) combinations in order 00, 01, 10, 11. After a programmable settle time it samples the three unit outputs and compares them with golden values. It then reports an error count, a per-vector failure mask and a pass flag. It sits on the board-level wrapper as the driving/observing end of the gate unit's interface.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before the check cycle; legal range 1..15.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  input  1  begin a sweep; acted on only in IDLE or DONE.
- `obsAND`  input  1  AND output of the unit under test.
- `obsOR`  input  1  OR output of the unit under test.
- `obsNOT`  input  1  NOT output of the unit under test.
- `drvA`  output  1  A input to the unit under test; reset value 0.
- `drvB`  output  1  B input to the unit under test; reset value 0.
- `busy`  output  1  high in SETTLE or CHECK; reset value 0.
- `done`  output  1  high in DONE; reset value 0.
- `pass`  output  1  high in DONE when `errCount`==0; otherwise 0; reset value 0.
- `errCount`  output  3  number of failing vectors, 0..4; reset value 0.
- `failMask`  output  4  bit k set when vector k (k = {A,B}) fails; reset value 0.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Reset forces IDLE.
- IDLE/DONE with `start`=1:
  - clear `errCount` and `failMask`, set `idx`=0 and `cnt`=0;
  - drive `drvA`=idx[1], `drvB`=idx[0];
  - go to SETTLE.
- SETTLE: if `cnt`==SETTLE_CYCLES-1, go to CHECK; else increment `cnt`. Drive outputs are held.
- CHECK (exactly one cycle), on the edge leaving CHECK:
  - compare `obsAND` against A&B, `obsOR` against A|B, and `obsNOT` against ~A, using the currently driven A and B;
  - any mismatch: `errCount`+=1 and `failMask[idx]`=1; at most one increment per vector;
  - if `idx`==3, go to DONE and drive `drvA`=`drvB`=0;
  - otherwise increment `idx`, drive the next vector, clear `cnt`, and go to SETTLE.
- DONE: `done`, `pass`, `errCount` and `failMask` hold until the next `start` or `reset`.
- `start` is ignored while `busy`=1. A held-high `start` in DONE restarts a sweep every time DONE is reached.
- Reset mid-sweep: next cycle is IDLE, and every output takes its reset value. Partial results are discarded.
- Width rules:
  - `errCount` saturates naturally at 4, because there are only four vectors, and never wraps.
  - `cnt` is 4 bits wide.
  - `idx` is 2 bits wide. Its increment from 3 never occurs because CHECK at `idx`=3 exits to DONE.

## Timing
- Let edge 0 be the edge that samples `start`=1. Vector 0 appears on `drvA`/`drvB` after edge 0.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in SETTLE plus one in CHECK.
- Vector k is driven from edge k·(S+1) and sampled at edge (k+1)·(S+1), where S = SETTLE_CYCLES.
- `done` rises after edge 4·(S+1). With the default S=2, that is 12 cycles after the start edge.
- `busy` is high from edge 0 up to edge 4·(S+1).
- Observed inputs are assumed combinational from `drvA`/`drvB` and stable within S cycles. Only the value present at the CHECK edge is used.

## Structure
- Package `lab1_pkg` holds:
  - the state encoding constants (IDLE=0, SETTLE=1, CHECK=2, DONE=3);
  - `NUM_VECTORS`=4;
  - the `errCount` and `failMask` widths.
- One sub-module, `gate_golden`, is purely combinational: (a, b) -> (expAND, expOR, expNOT). The checker compares the unit's outputs against it.
- The top level contains the FSM, the `idx`/`cnt` counters and the result registers.

## Test plan
- Correct NOR-built unit, S=2, `start` pulse for 1 cycle:
  - drive sequence 00, 01, 10, 11, each held 3 cycles;
  - `done` after 12 cycles, `pass`=1, `errCount`=0, `failMask`=0000.
- Faulty unit with `obsOR` stuck at 0 -> vectors 01, 10 and 11 fail; `errCount`=3, `failMask`=1110, `pass`=0.
- Faulty unit with `obsNOT`=B instead of ~A -> vectors 00 and 11 fail; `errCount`=2, `failMask`=1001.
- `reset` asserted during vector 2's SETTLE:
  - next cycle is IDLE with all outputs 0;
  - a following `start` yields a clean full 12-cycle sweep.
- `start` pulsed while `busy` -> no effect on timing or results. `start` in DONE -> results clear on the start edge and a new sweep runs.
- S=1 -> `done` 8 cycles after the start edge. S=15 -> `done` after 64 cycles.

Source files
------------

// File: rtl/lab1_pkg.sv
// Shared constants for the NOR-gate unit sweep tester.
//   state_e      : sweep FSM state encoding
//   NUM_VECTORS  : number of (A,B) input combinations applied per sweep
//   ERR_COUNT_W  : width of the failing-vector counter (holds 0..4)
//   FAIL_MASK_W  : width of the per-vector failure mask
package lab1_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned ERR_COUNT_W = 3;
  localparam int unsigned FAIL_MASK_W = NUM_VECTORS;

endpackage

// File: rtl/gate_golden.sv
// Golden reference for the NOR-built logic unit: purely combinational.
//   a_i, b_i        : unit inputs A and B
//   exp_and_o       : expected A & B
//   exp_or_o        : expected A | B
//   exp_not_o       : expected ~A
module gate_golden (
  input  logic a_i,
  input  logic b_i,
  output logic exp_and_o,
  output logic exp_or_o,
  output logic exp_not_o
);

  assign exp_and_o = a_i & b_i;
  assign exp_or_o  = a_i | b_i;
  assign exp_not_o = ~a_i;

endmodule

// File: rtl/nor_gate_sweep_tester.sv
// Stimulus driver and response checker for the NOR-built gate unit. On start it
// applies (A,B) = 00, 01, 10, 11, holds each for SETTLE_CYCLES cycles, checks the
// unit outputs in one CHECK cycle and accumulates an error count and failure mask.
//   clk, reset         : clock, synchronous active-high reset
//   start              : begin a sweep (honoured in IDLE or DONE only)
//   obsAND/obsOR/obsNOT: outputs of the unit under test
//   drvA, drvB         : inputs driven to the unit under test
//   busy, done, pass   : status (SETTLE/CHECK, DONE, DONE with no errors)
//   errCount, failMask : number of failing vectors, bit k = vector {A,B}=k failed
module nor_gate_sweep_tester
  import lab1_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   obsAND,
  input  logic                   obsOR,
  input  logic                   obsNOT,
  output logic                   drvA,
  output logic                   drvB,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_COUNT_W-1:0] errCount,
  output logic [FAIL_MASK_W-1:0] failMask
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [1:0]             drv_q, drv_d;  // {A, B}
  logic [ERR_COUNT_W-1:0] err_q, err_d;
  logic [FAIL_MASK_W-1:0] mask_q, mask_d;

  logic exp_and, exp_or, exp_not;
  logic mismatch;

  gate_golden u_golden (
    .a_i       (drv_q[1]),
    .b_i       (drv_q[0]),
    .exp_and_o (exp_and),
    .exp_or_o  (exp_or),
    .exp_not_o (exp_not)
  );

  assign mismatch = (obsAND != exp_and) | (obsOR != exp_or) | (obsNOT != exp_not);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    err_d   = err_q;
    mask_d  = mask_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = '0;
          mask_d  = '0;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          drv_d   = 2'b00;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CntLast) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCheck: begin
        // One increment per vector at most; four vectors keep errCount <= 4.
        if (mismatch) begin
          err_d         = err_q + ERR_COUNT_W'(1);
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          drv_d   = 2'b00;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          drv_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      drv_q   <= 2'b00;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign drvA     = drv_q[1];
  assign drvB     = drv_q[0];
  assign busy     = (state_q == StSettle) || (state_q == StCheck);
  assign done     = (state_q == StDone);
  assign pass     = (state_q == StDone) && (err_q == '0);
  assign errCount = err_q;
  assign failMask = mask_q;

endmodule

// File: tb/tb_nor_gate_sweep_tester.sv
module tb_nor_gate_sweep_tester;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] start_v, drvA_v, drvB_v, busy_v, done_v, pass_v;
  logic [2:0] obsAND_v, obsOR_v, obsNOT_v;
  logic [2:0] err_v [3];
  logic [3:0] mask_v [3];

  // Unit-under-test behaviour: 0 good, 1 OR stuck 0, 2 NOT=B, 3 per-vector xor corruption
  int         mode;
  logic [2:0] xmask [4];

  int errors = 0;
  int checks = 0;
  int unsigned s_of [3] = '{2, 1, 15};

  always #5 clk = ~clk;

  nor_gate_sweep_tester #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .obsAND(obsAND_v[0]), .obsOR(obsOR_v[0]), .obsNOT(obsNOT_v[0]),
    .drvA(drvA_v[0]), .drvB(drvB_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .errCount(err_v[0]), .failMask(mask_v[0])
  );

  nor_gate_sweep_tester #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .obsAND(obsAND_v[1]), .obsOR(obsOR_v[1]), .obsNOT(obsNOT_v[1]),
    .drvA(drvA_v[1]), .drvB(drvB_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .errCount(err_v[1]), .failMask(mask_v[1])
  );

  nor_gate_sweep_tester #(.SETTLE_CYCLES(15)) u_dut_s15 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .obsAND(obsAND_v[2]), .obsOR(obsOR_v[2]), .obsNOT(obsNOT_v[2]),
    .drvA(drvA_v[2]), .drvB(drvB_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .errCount(err_v[2]), .failMask(mask_v[2])
  );

  function automatic logic [2:0] unit_resp(input logic a, input logic b, input int m,
                                           input logic [2:0] x);
    logic [2:0] g;
    g = {a & b, a | b, ~a};
    case (m)
      1: g[1] = 1'b0;
      2: g[0] = b;
      3: g = g ^ x;
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    obsAND_v = '0;
    obsOR_v  = '0;
    obsNOT_v = '0;
    for (int i = 0; i < 3; i++) begin
      {obsAND_v[i], obsOR_v[i], obsNOT_v[i]} =
        unit_resp(drvA_v[i], drvB_v[i], mode, xmask[{drvA_v[i], drvB_v[i]}]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input int inst, input string tag);
    check({tag, "_drv"},  {drvA_v[inst], drvB_v[inst]}, 0);
    check({tag, "_busy"}, busy_v[inst], 0);
    check({tag, "_done"}, done_v[inst], 0);
    check({tag, "_pass"}, pass_v[inst], 0);
    check({tag, "_err"},  err_v[inst], 0);
    check({tag, "_mask"}, mask_v[inst], 0);
  endtask

  // One full sweep: vector k driven for S+1 cycles from edge k*(S+1), done at edge 4*(S+1).
  task automatic sweep(input int inst, input logic [3:0] exp_mask, input bit pulse_busy);
    int unsigned s;
    int total;
    int pt;
    logic [1:0] ev;
    s = s_of[inst];
    total = 4 * (int'(s) + 1);
    pt = pulse_busy ? int'($urandom_range(total - 1, 1)) : -1;
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    check("start_busy", busy_v[inst], 1);
    check("start_clear_err", err_v[inst], 0);
    check("start_clear_mask", mask_v[inst], 0);
    check("start_vec0", {drvA_v[inst], drvB_v[inst]}, 0);
    for (int t = 1; t <= total; t++) begin
      @(posedge clk); #1;
      start_v[inst] = (t == pt);
      if (t < total) begin
        ev = 2'(t / (int'(s) + 1));
        check("run_drv", {drvA_v[inst], drvB_v[inst]}, ev);
        check("run_busy", busy_v[inst], 1);
        check("run_done", done_v[inst], 0);
      end else begin
        check("end_done", done_v[inst], 1);
        check("end_busy", busy_v[inst], 0);
        check("end_drv", {drvA_v[inst], drvB_v[inst]}, 0);
        check("end_err", err_v[inst], $countones(exp_mask));
        check("end_mask", mask_v[inst], exp_mask);
        check("end_pass", pass_v[inst], exp_mask == 4'b0000);
      end
    end
    start_v[inst] = 1'b0;
    @(posedge clk); #1;
    check("hold_done", done_v[inst], 1);
    check("hold_mask", mask_v[inst], exp_mask);
  endtask

  initial begin
    logic [3:0] rmask;
    reset = 1'b1;
    start_v = '0;
    mode = 0;
    for (int k = 0; k < 4; k++) xmask[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) check_all_zero(i, "reset");

    // Good unit, then the two directed faults.
    mode = 0;
    sweep(0, 4'b0000, 1'b0);
    mode = 1;
    sweep(0, 4'b1110, 1'b1);
    mode = 2;
    sweep(0, 4'b1001, 1'b1);

    // Reset during vector 2's SETTLE (vector 2 driven from edge 6 with S=2).
    mode = 1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_drv", {drvA_v[0], drvB_v[0]}, 2'b10);
    check("mid_err", err_v[0], 1);
    check("mid_mask", mask_v[0], 4'b0010);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero(0, "midrst");
    mode = 0;
    sweep(0, 4'b0000, 1'b0);

    // Other settle lengths.
    sweep(1, 4'b0000, 1'b0);
    sweep(2, 4'b0000, 1'b1);

    // Random per-vector corruption against a per-vector fail model.
    mode = 3;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        xmask[k] = ($urandom_range(1, 0) == 1) ? 3'($urandom_range(7, 1)) : 3'd0;
        rmask[k] = (xmask[k] != 3'd0);
      end
      sweep(r % 3, rmask, 1'b1);
    end

    // Held-high start in DONE restarts (S=1: done at edge 8, restart at edge 9).
    mode = 0;
    for (int k = 0; k < 4; k++) xmask[k] = '0;
    @(negedge clk);
    start_v[1] = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("held_done", done_v[1], 1);
    check("held_pass", pass_v[1], 1);
    @(posedge clk); #1;
    check("held_restart", busy_v[1], 1);
    start_v[1] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
